// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the intersection controller and its environment:
// detector/button inputs toward the controller, lamp and status outputs back.
interface traffic_phase_scheduler_if;
  logic       ns_car;
  logic       ew_car;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  // Environment side: drives detectors and button, observes lamps.
  modport master (
    output ns_car, ew_car, ped_req,
    input  ns_light, ew_light, walk, ped_pending, phase
  );

  // Controller side.
  modport slave (
    input  ns_car, ew_car, ped_req,
    output ns_light, ew_light, walk, ped_pending, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Actuated two-phase intersection controller: NS/EW green, yellow and
// all-red clearance with demand-driven min/max green, plus a pedestrian
// WALK phase inserted after an all-red interval when a request is latched.
// Lamp outputs are Moore-decoded from the state register.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 30,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  parameter int WALK      = 8,
  parameter int TW        = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  traffic_phase_scheduler_if.slave    bus
);

  // State codes double as the debug phase output.
  localparam logic [2:0] S_NS_G   = 3'd0;
  localparam logic [2:0] S_NS_Y   = 3'd1;
  localparam logic [2:0] S_AR_NS  = 3'd2;
  localparam logic [2:0] S_EW_G   = 3'd3;
  localparam logic [2:0] S_EW_Y   = 3'd4;
  localparam logic [2:0] S_AR_EW  = 3'd5;
  localparam logic [2:0] S_WALK_S = 3'd6;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  // Exit thresholds: a state that "lasts N" leaves when timer == N-1.
  localparam logic [TW-1:0] MIN_M1  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_M1  = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_M1  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] AR_M1   = TW'(ALL_RED - 1);
  localparam logic [TW-1:0] WALK_M1 = TW'(WALK - 1);
  localparam logic [TW-1:0] TIMER_TOP = {TW{1'b1}};

  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic          r_from_dir;
  logic          r_ped_pending;

  logic [2:0]    w_next_state;
  logic          w_next_from_dir;
  logic          w_state_change;
  logic          w_enter_walk;
  logic          w_in_green;
  logic          w_min_done;
  logic          w_max_done;
  logic          w_ns_exit;
  logic          w_ew_exit;

  assign w_in_green = (r_state == S_NS_G) || (r_state == S_EW_G);
  assign w_min_done = (r_timer >= MIN_M1);
  assign w_max_done = (r_timer >= MAX_M1);

  // Green may end only after minimum time and with opposing demand (a car
  // or a waiting pedestrian); continued own demand extends it up to max.
  assign w_ns_exit = w_min_done && (bus.ew_car || r_ped_pending) &&
                     (!bus.ns_car || w_max_done);
  assign w_ew_exit = w_min_done && (bus.ns_car || r_ped_pending) &&
                     (!bus.ew_car || w_max_done);

  // Next-state and walk-origin selection.
  always_comb begin
    w_next_state    = r_state;
    w_next_from_dir = r_from_dir;
    case (r_state)
      S_NS_G: begin
        if (w_ns_exit) w_next_state = S_NS_Y;
        else           w_next_state = S_NS_G;
      end
      S_NS_Y: begin
        if (r_timer >= YEL_M1) w_next_state = S_AR_NS;
        else                   w_next_state = S_NS_Y;
      end
      S_AR_NS: begin
        if (r_timer >= AR_M1) begin
          if (r_ped_pending) begin
            w_next_state    = S_WALK_S;
            w_next_from_dir = DIR_NS;
          end else begin
            w_next_state    = S_EW_G;
          end
        end else begin
          w_next_state = S_AR_NS;
        end
      end
      S_EW_G: begin
        if (w_ew_exit) w_next_state = S_EW_Y;
        else           w_next_state = S_EW_G;
      end
      S_EW_Y: begin
        if (r_timer >= YEL_M1) w_next_state = S_AR_EW;
        else                   w_next_state = S_EW_Y;
      end
      S_AR_EW: begin
        if (r_timer >= AR_M1) begin
          if (r_ped_pending) begin
            w_next_state    = S_WALK_S;
            w_next_from_dir = DIR_EW;
          end else begin
            w_next_state    = S_NS_G;
          end
        end else begin
          w_next_state = S_AR_EW;
        end
      end
      S_WALK_S: begin
        // Service alternates: after a walk taken from NS, give EW the green.
        if (r_timer >= WALK_M1) begin
          if (r_from_dir == DIR_NS) w_next_state = S_EW_G;
          else                      w_next_state = S_NS_G;
        end else begin
          w_next_state = S_WALK_S;
        end
      end
      default: begin
        w_next_state = S_NS_G;
      end
    endcase
  end

  assign w_state_change = (w_next_state != r_state);
  assign w_enter_walk   = w_state_change && (w_next_state == S_WALK_S);

  // State, walk origin and phase timer; the timer restarts on every entry
  // and saturates so a resting green can never wrap back below its limits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_NS_G;
      r_timer    <= {TW{1'b0}};
      r_from_dir <= DIR_NS;
    end else begin
      r_state    <= w_next_state;
      r_from_dir <= w_next_from_dir;
      if (w_state_change) begin
        r_timer <= {TW{1'b0}};
      end else if (w_in_green && w_max_done) begin
        r_timer <= MAX_M1;
      end else if (r_timer != TIMER_TOP) begin
        r_timer <= r_timer + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        r_timer <= r_timer;
      end
    end
  end

  // Pedestrian request latch: cleared on walk entry (clear beats a new
  // press), presses during the walk itself are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ped_pending <= 1'b0;
    end else if (w_enter_walk) begin
      r_ped_pending <= 1'b0;
    end else if (r_state == S_WALK_S) begin
      r_ped_pending <= r_ped_pending;
    end else if (bus.ped_req) begin
      r_ped_pending <= 1'b1;
    end else begin
      r_ped_pending <= r_ped_pending;
    end
  end

  // Moore lamp decode from the state register; unknown codes show all-red.
  always_comb begin
    bus.ns_light = LAMP_RED;
    bus.ew_light = LAMP_RED;
    bus.walk     = 1'b0;
    case (r_state)
      S_NS_G:   bus.ns_light = LAMP_GREEN;
      S_NS_Y:   bus.ns_light = LAMP_YELLOW;
      S_EW_G:   bus.ew_light = LAMP_GREEN;
      S_EW_Y:   bus.ew_light = LAMP_YELLOW;
      S_WALK_S: bus.walk     = 1'b1;
      default: begin
        bus.ns_light = LAMP_RED;
        bus.ew_light = LAMP_RED;
        bus.walk     = 1'b0;
      end
    endcase
  end

  assign bus.phase       = r_state;
  assign bus.ped_pending = r_ped_pending;

endmodule
